// File: rtl/sound_scheduler.sv
// -----------------------------------------------------------------------------
// sound_scheduler
//
// Plays one of four fixed sound effects out of a shared 8-bit sample ROM into
// a codec DAC FIFO. Requests are latched as pending bits. A higher-priority
// request preempts the active sound, and a lower-priority request waits until
// the active sound ends. While nothing is playing, the codec receives a stream
// of silent samples so that its FIFO never runs dry.
//
// Ports
//   CLOCK_50      system clock
//   reset         synchronous reset, active-high
//   req_start     one-cycle request for sound 0 (start)
//   req_chomp     one-cycle request for sound 1 (chomp)
//   req_eatghost  one-cycle request for sound 2 (eatghost)
//   req_death     one-cycle request for sound 3 (death)
//   rom_addr      sample ROM address (ADDR_W bits); held outside FETCH
//   rom_q         ROM data, unsigned; valid one cycle after rom_addr
//   write_ready   codec DAC FIFO can accept a sample
//   write         codec write strobe
//   sample        signed 24-bit sample to the codec (same on left and right)
//   busy          a sound is playing
//   playing       id of the active sound (0 when idle)
//   done          one-cycle pulse when a sound ends without being preempted
//
// Parameters
//   ADDR_W        sample ROM address width
//   DIV           CLOCK_50 cycles per sample period
// -----------------------------------------------------------------------------
module sound_scheduler #(
    parameter int ADDR_W = 16,
    parameter int DIV    = 1042
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req_start,
    input  logic              req_chomp,
    input  logic              req_eatghost,
    input  logic              req_death,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    input  logic              write_ready,
    output logic              write,
    output logic [23:0]       sample,
    output logic              busy,
    output logic [1:0]        playing,
    output logic              done
);

    localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [1:0] ID_START    = 2'd0;
    localparam logic [1:0] ID_CHOMP    = 2'd1;
    localparam logic [1:0] ID_EATGHOST = 2'd2;
    localparam logic [1:0] ID_DEATH    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT_TICK,
        S_PUSH
    } state_t;

    // Segment table: where each sound lives in the ROM and how long it is.
    function automatic logic [ADDR_W-1:0] seg_base(input logic [1:0] id);
        case (id)
            ID_START:    seg_base = ADDR_W'(32'h0000);
            ID_CHOMP:    seg_base = ADDR_W'(32'h4000);
            ID_EATGHOST: seg_base = ADDR_W'(32'h4800);
            default:     seg_base = ADDR_W'(32'h5800);
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] seg_len(input logic [1:0] id);
        case (id)
            ID_START:    seg_len = ADDR_W'(32'h4000);
            ID_CHOMP:    seg_len = ADDR_W'(32'h0800);
            ID_EATGHOST: seg_len = ADDR_W'(32'h1000);
            default:     seg_len = ADDR_W'(32'h2000);
        endcase
    endfunction

    // Priority rank: larger wins (death > start > eatghost > chomp).
    function automatic logic [1:0] id_rank(input logic [1:0] id);
        case (id)
            ID_DEATH:    id_rank = 2'd3;
            ID_START:    id_rank = 2'd2;
            ID_EATGHOST: id_rank = 2'd1;
            default:     id_rank = 2'd0;
        endcase
    endfunction

    state_t              state_reg, state_next;
    logic [3:0]          pending_reg, pending_next;
    logic [1:0]          active_reg, active_next;
    logic [ADDR_W-1:0]   offset_reg, offset_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                armed_reg, armed_next;
    logic [ADDR_W-1:0]   rom_addr_reg, rom_addr_next;
    logic [23:0]         sample_reg, sample_next;
    logic                reset_q_reg;

    logic [3:0]          req_vec;
    logic [3:0]          new_req;
    logic [3:0]          eff_pending;
    logic                any_pending;
    logic [1:0]          top_id;
    logic                busy_int;
    logic                preempt;
    logic                tick;
    logic                last;
    logic                grant;
    logic                restart;

    assign req_vec  = {req_death, req_eatghost, req_chomp, req_start};
    assign busy_int = (state_reg != S_IDLE);

    // A request is dropped when it is for the sound already playing. It is
    // also dropped when it coincides with reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign new_req[gi] = req_vec[gi] && !reset &&
                                 !(busy_int && (active_reg == 2'(gi)));
        end
    endgenerate

    // Pending set as seen by this cycle's selection. It includes requests
    // arriving now, so a request that lands on the final sample is picked up
    // straight away. A death request wipes everything else.
    assign eff_pending = new_req[ID_DEATH] ? 4'b1000 : (pending_reg | new_req);
    assign any_pending = |eff_pending;

    always_comb begin
        top_id = ID_CHOMP;
        if (eff_pending[ID_DEATH])
            top_id = ID_DEATH;
        else if (eff_pending[ID_START])
            top_id = ID_START;
        else if (eff_pending[ID_EATGHOST])
            top_id = ID_EATGHOST;
    end

    assign preempt = busy_int && any_pending && (id_rank(top_id) > id_rank(active_reg));
    assign tick    = busy_int && (count_reg == CNT_MAX);
    assign last    = (offset_reg == seg_len(active_reg) - ADDR_W'(1));

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            pending_reg  <= '0;
            active_reg   <= ID_START;
            offset_reg   <= '0;
            count_reg    <= '0;
            armed_reg    <= 1'b0;
            rom_addr_reg <= '0;
            sample_reg   <= '0;
            reset_q_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            active_reg   <= active_next;
            offset_reg   <= offset_next;
            count_reg    <= count_next;
            armed_reg    <= armed_next;
            rom_addr_reg <= rom_addr_next;
            sample_reg   <= sample_next;
            reset_q_reg  <= 1'b0;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_next   = state_reg;
        pending_next = eff_pending;
        active_next  = active_reg;
        offset_next  = offset_reg;
        armed_next   = armed_reg;
        grant        = 1'b0;
        restart      = 1'b0;

        if (state_reg == S_IDLE) begin
            if (any_pending) begin
                grant   = 1'b1;
                restart = 1'b1;
            end
        end else if (preempt) begin
            // The preempted sound is discarded. It is not re-queued.
            grant   = 1'b1;
            restart = 1'b1;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    state_next = S_LOAD;
                    if (tick)
                        armed_next = 1'b1;
                end
                S_LOAD: begin
                    state_next = S_WAIT_TICK;
                    if (tick)
                        armed_next = 1'b1;
                end
                S_WAIT_TICK: begin
                    // A tick seen during FETCH/LOAD still counts. A tick seen
                    // during a stalled PUSH never reaches here, so a late
                    // sample waits for a fresh tick.
                    if (tick || armed_reg) begin
                        state_next = S_PUSH;
                        armed_next = 1'b0;
                    end
                end
                S_PUSH: begin
                    if (write_ready) begin
                        if (last) begin
                            if (any_pending)
                                grant = 1'b1;
                            else
                                state_next = S_IDLE;
                        end else begin
                            offset_next = offset_reg + ADDR_W'(1);
                            state_next  = S_FETCH;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (grant) begin
            state_next   = S_FETCH;
            active_next  = top_id;
            offset_next  = '0;
            pending_next = eff_pending & ~(4'b0001 << top_id);
        end
        if (restart)
            armed_next = 1'b0;
    end

    // The sample clock runs only while a sound is active. It restarts from
    // zero whenever playback starts from idle or is preempted.
    always_comb begin
        count_next = '0;
        if (busy_int && !restart)
            count_next = tick ? '0 : count_reg + CNT_W'(1);
    end

    // The address is loaded on entry to FETCH, so it is valid during FETCH
    // and the ROM data is valid during LOAD.
    always_comb begin
        rom_addr_next = rom_addr_reg;
        if (state_next == S_FETCH)
            rom_addr_next = seg_base(active_next) + offset_next;
    end

    always_comb begin
        sample_next = sample_reg;
        if (state_reg == S_LOAD)
            sample_next = {rom_q ^ 8'h80, 16'h0000};
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        rom_addr = rom_addr_reg;
        busy     = busy_int;
        playing  = busy_int ? active_reg : 2'd0;
        sample   = (state_reg == S_IDLE) ? 24'h000000 : sample_reg;
        // Silence is streamed in IDLE. It is held off for the cycle right
        // after reset so that reset visibly quiets the strobe.
        write    = write_ready && !reset_q_reg &&
                   ((state_reg == S_IDLE) || (state_reg == S_PUSH));
        done     = (state_reg == S_PUSH) && write_ready && last && !preempt;
    end

endmodule

// File: tb/tb_sound_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sound_scheduler
//
// Self-checking bench for sound_scheduler (DIV = 4). A reference model keeps
// the pending set and the active sound. When a sound is granted, the model
// pushes that sound's full sample list into a scoreboard queue. A monitor
// pops one entry on every codec write strobe and compares it. Directed
// scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sound_scheduler;

    localparam int ADDR_W = 16;
    localparam int DIV    = 4;

    logic              CLOCK_50;
    logic              reset;
    logic              req_start, req_chomp, req_eatghost, req_death;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic              write_ready;
    logic              write;
    logic [23:0]       sample;
    logic              busy;
    logic [1:0]        playing;
    logic              done;

    sound_scheduler #(.ADDR_W(ADDR_W), .DIV(DIV)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .req_start    (req_start),
        .req_chomp    (req_chomp),
        .req_eatghost (req_eatghost),
        .req_death    (req_death),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .write_ready  (write_ready),
        .write        (write),
        .sample       (sample),
        .busy         (busy),
        .playing      (playing),
        .done         (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Sample ROM with a one-cycle read latency.
    logic [7:0] rom_mem [0:65535];
    always @(posedge CLOCK_50) rom_q <= rom_mem[rom_addr];

    // Sound table and priority, written as plain lookup data.
    int seg_base [4] = '{32'h0000, 32'h4000, 32'h4800, 32'h5800};
    int seg_len  [4] = '{32'h4000, 32'h0800, 32'h1000, 32'h2000};
    int rank_of  [4] = '{2, 0, 1, 3};
    int prio_ord [4] = '{3, 0, 2, 1};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model state
    int          cur = -1;          // active sound id, -1 when idle
    logic [3:0]  pend = 4'b0;
    logic [23:0] exp_q [$];
    bit          last_pop = 0;

    // Monitor logs
    int          sound_writes = 0;
    int          done_cnt = 0;
    int          addr_log [$];
    logic [23:0] smp_log [$];
    logic [ADDR_W-1:0] prev_addr = '0;

    task automatic load_sound(input int id);
        exp_q.delete();
        for (int k = 0; k < seg_len[id]; k++)
            exp_q.push_back({rom_mem[seg_base[id] + k] ^ 8'h80, 16'h0000});
    endtask

    // ---------------------------------------------------------------- monitor
    always begin : monitor
        logic [23:0] e;
        @(negedge CLOCK_50);
        last_pop = 0;
        if (rom_addr !== prev_addr) begin
            addr_log.push_back(int'(rom_addr));
            prev_addr = rom_addr;
        end
        if (done === 1'b1)
            done_cnt++;
        if (write === 1'b1) begin
            if (cur < 0) begin
                chk("silence", {8'h0, sample}, 32'd0);
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got write of 0x%0h, required no write (sound %0d exhausted)",
                         sample, cur);
            end else begin
                e = exp_q.pop_front();
                chk("sample", {8'h0, sample}, {8'h0, e});
                sound_writes++;
                smp_log.push_back(sample);
                if (exp_q.size() == 0)
                    last_pop = 1;
            end
        end
    end

    // ------------------------------------------------------- reference model
    always begin : model
        logic [3:0] r, eff;
        int         top;
        bit         pre;
        @(negedge CLOCK_50);
        #2;
        chk("busy", {31'd0, busy}, {31'd0, (cur >= 0)});
        chk("playing", {30'd0, playing}, (cur >= 0) ? cur : 0);

        r = reset ? 4'b0 : {req_death, req_eatghost, req_chomp, req_start};
        if (cur >= 0)
            r[cur] = 1'b0;
        eff = r[3] ? 4'b1000 : (pend | r);
        top = -1;
        for (int k = 0; k < 4; k++)
            if (top < 0 && eff[prio_ord[k]])
                top = prio_ord[k];
        pre = (cur >= 0) && (top >= 0) && (rank_of[top] > rank_of[cur]);
        chk("done", {31'd0, done}, {31'd0, (last_pop && !pre)});

        if (reset) begin
            cur  = -1;
            pend = 4'b0;
            exp_q.delete();
        end else if (pre || (cur >= 0 && last_pop && top >= 0) || (cur < 0 && top >= 0)) begin
            cur  = top;
            pend = eff & ~(4'b0001 << top);
            load_sound(top);
        end else begin
            if (cur >= 0 && last_pop)
                cur = -1;
            pend = eff;
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        {req_death, req_eatghost, req_chomp, req_start} = m;
        cyc(1);
        {req_death, req_eatghost, req_chomp, req_start} = 4'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string nm);
        int n = 0;
        while (sound_writes < target && n < budget) begin
            cyc(1);
            n++;
        end
        if (sound_writes < target) begin
            total++;
            bad++;
            $display("FAIL %s: writes=%0d after %0d cycles, required %0d", nm, sound_writes, n, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            cyc(1);
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s: still busy after %0d cycles, required idle", nm, n);
        end
    endtask

    task automatic check_run(input int bi, input int base, input int n, input string nm);
        int mism = 0;
        for (int i = 0; i < n; i++)
            if (bi + i >= addr_log.size() || addr_log[bi + i] != base + i)
                mism++;
        chk(nm, mism, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin : stim
        int bw, bd, ba, bs;
        for (int a = 0; a < 65536; a++)
            rom_mem[a] = 8'($urandom);
        rom_mem[16'h4000] = 8'h00;
        rom_mem[16'h4001] = 8'h80;
        rom_mem[16'h4002] = 8'hFF;

        reset = 1'b1;
        {req_death, req_eatghost, req_chomp, req_start} = 4'b0;
        write_ready = 1'b1;
        cyc(2);

        // Reset state
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_playing", {30'd0, playing}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
        cyc(1);
        chk("idle_silence_write", {31'd0, write}, 32'd1);
        chk("idle_silence_sample", {8'd0, sample}, 32'd0);

        // Single chomp, played to the end
        bw = sound_writes; bd = done_cnt; ba = addr_log.size(); bs = smp_log.size();
        pulse(4'b0010);
        wait_idle(12000, "s2_idle");
        chk("s2_writes", sound_writes - bw, 32'd2048);
        chk("s2_done", done_cnt - bd, 32'd1);
        chk("s2_addr_count", addr_log.size() - ba, 32'd2048);
        check_run(ba, 32'h4000, 2048, "s2_addr_order");
        chk("s2_q00", {8'd0, smp_log[bs]}, 32'h800000);
        chk("s2_q80", {8'd0, smp_log[bs + 1]}, 32'h000000);
        chk("s2_qFF", {8'd0, smp_log[bs + 2]}, 32'h7F0000);

        // Death preempts chomp at offset 10
        bw = sound_writes; bd = done_cnt;
        pulse(4'b0010);
        wait_writes(bw + 10, 200, "s3_wait");
        pulse(4'b1000);
        chk("s3_rom_addr", {16'd0, rom_addr}, 32'h5800);
        chk("s3_playing", {30'd0, playing}, 32'd3);
        cyc(20);
        chk("s3_no_done", done_cnt - bd, 32'd0);
        do_reset();

        // Chomp and eatghost requested together
        bd = done_cnt; ba = addr_log.size();
        pulse(4'b0110);
        wait_idle(30000, "s4_idle");
        chk("s4_addr_count", addr_log.size() - ba, 32'd6144);
        check_run(ba, 32'h4800, 4096, "s4_eatghost_addr");
        check_run(ba + 4096, 32'h4000, 2048, "s4_chomp_addr");
        chk("s4_done", done_cnt - bd, 32'd2);

        // Codec stall during PUSH for longer than 3*DIV cycles
        bw = sound_writes; bd = done_cnt; ba = addr_log.size();
        pulse(4'b0010);
        wait_writes(bw + 5, 200, "s5_wait");
        write_ready = 1'b0;
        cyc(3 * DIV + 8);
        chk("s5_stall_no_write", {31'd0, write}, 32'd0);
        write_ready = 1'b1;
        wait_idle(12000, "s5_idle");
        chk("s5_writes", sound_writes - bw, 32'd2048);
        check_run(ba, 32'h4000, 2048, "s5_addr_order");
        chk("s5_done", done_cnt - bd, 32'd1);

        // Reset in the middle of start
        bw = sound_writes;
        pulse(4'b0001);
        wait_writes(bw + 100, 800, "s6_wait");
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("s6_busy", {31'd0, busy}, 32'd0);
        chk("s6_write", {31'd0, write}, 32'd0);
        chk("s6_playing", {30'd0, playing}, 32'd0);
        cyc(3);
        chk("s6_nothing_pending", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        req_chomp = 1'b1;
        cyc(1);
        reset = 1'b0;
        req_chomp = 1'b0;
        cyc(3);
        chk("s6_req_in_reset_ignored", {31'd0, busy}, 32'd0);
        pulse(4'b0001);
        chk("s6_restart_addr", {16'd0, rom_addr}, 32'h0000);
        chk("s6_restart_busy", {31'd0, busy}, 32'd1);
        bw = sound_writes;
        wait_writes(bw + 20, 200, "s6_restart_wait");
        do_reset();

        // Randomized phase
        for (int i = 0; i < 15000; i++) begin
            req_start    = ($urandom_range(0, 199) == 0);
            req_chomp    = ($urandom_range(0, 39) == 0);
            req_eatghost = ($urandom_range(0, 79) == 0);
            req_death    = ($urandom_range(0, 299) == 0);
            write_ready  = ($urandom_range(0, 9) != 0);
            reset        = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        {req_death, req_eatghost, req_chomp, req_start} = 4'b0;
        write_ready = 1'b1;
        do_reset();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: sample ROM address width.
REQ-002 SHALL have parameter DIV, default 1042: CLOCK_50 cycles per sample period (about 48 kHz).
REQ-003 SHALL have these ports, with reset synchronous and active-high on clock CLOCK_50:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous reset, active-high
- req_start, req_chomp, req_eatghost, req_death  in  1 each  one-cycle sound requests
- rom_addr  out  ADDR_W  sample ROM address
- rom_q  in  8  ROM data, unsigned, valid 1 cycle after rom_addr
- write_ready  in  1  codec DAC FIFO can accept a sample
- write  out  1  codec write strobe
- sample  out  24  signed sample to codec, left = right
- busy  out  1  a sound is playing
- playing  out  2  active sound id: 0 start, 1 chomp, 2 eatghost, 3 death
- done  out  1  one-cycle pulse when a sound ends naturally

Function
REQ-004 SHALL use a fixed segment table of (base, len): start (0x0000, 0x4000), chomp (0x4000, 0x0800), eatghost (0x4800, 0x1000), death (0x5800, 0x2000).
REQ-005 SHALL use priority death > start > eatghost > chomp.
REQ-006 SHALL latch each request into a pending bit, except a request for the id currently playing, which is ignored.
REQ-007 SHALL, on a death request, clear all other pending bits.
REQ-008 SHALL let a pending id with higher priority than the active one preempt it on the next cycle: offset returns to 0, there is no done pulse, and the preempted sound is discarded.
REQ-009 SHALL hold lower-priority pending ids until the active sound ends.
REQ-010 SHALL use states IDLE, FETCH, LOAD, WAIT_TICK and PUSH:
- IDLE -> FETCH when any bit is pending; the highest-priority pending bit is cleared and its id becomes active.
- FETCH drives rom_addr = base + offset.
- LOAD registers sample = {rom_q ^ 8'h80, 16'h0000}.
- WAIT_TICK waits for the sample tick.
- PUSH asserts write = write_ready and leaves on the first cycle where write_ready = 1.
REQ-011 SHALL, on leaving PUSH:
- if offset == len-1, pulse done and go to FETCH of the next pending id, or to IDLE if none is pending;
- otherwise increment offset and go to FETCH.
REQ-012 SHALL run the tick counter 0..DIV-1 only while busy; tick = (count == DIV-1); the counter is cleared on entering FETCH from IDLE and on preemption.
REQ-013 SHALL, if PUSH stalls past the next tick, not drop or repeat samples: the late tick is ignored and the next sample waits for a fresh tick.
REQ-014 SHALL, in IDLE, drive sample = 0 and write = write_ready so the codec keeps receiving silence.
REQ-015 SHALL hold rom_addr at its last value outside FETCH.
REQ-016 SHALL drive busy = (state != IDLE) and playing = active id; playing = 0 in IDLE.
REQ-017 SHALL grant simultaneous requests in one cycle by priority and leave the others pending.
REQ-018 SHALL consider a request arriving in the same cycle as done for the next selection.
REQ-019 SHALL wrap offset arithmetic at ADDR_W bits; base + len never exceeds 2^ADDR_W.

Reset
REQ-020 SHALL, on reset (including mid-sound), within one cycle:
- go to IDLE;
- clear all pending bits, offset, tick count and the sample register;
- drive rom_addr = 0, write = 0, busy = 0, playing = 0, done = 0.
REQ-021 SHALL ignore requests asserted in the same cycle as reset.

Verification
REQ-022 SHALL cover these directed scenarios:
- Single chomp, DIV = 4, write_ready = 1: exactly 2048 writes, rom_addr 0x4000..0x47FF in order, done pulses once, then IDLE.
- rom_q = 0x00, 0x80, 0xFF -> sample = 0x800000, 0x000000, 0x7F0000.
- Chomp playing, req_death at offset 10: next FETCH rom_addr = 0x5800, playing = 3, no done pulse for chomp.
- req_chomp and req_eatghost in the same cycle: eatghost plays fully (0x4800..0x57FF), then chomp plays.
- write_ready held low for 3*DIV cycles during PUSH: the sample is written once, no sample is skipped, and the addresses stay contiguous.
- reset asserted mid-start at offset 100: the next cycle shows busy = 0, write = 0, nothing pending; a later req_start begins again at rom_addr 0x0000.
